// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// jtag_pkg : opcodes, IR capture pattern, TAP-state enum and IR decode helper
// Rev 1.0
// ============================================================================
package jtag_pkg;

   localparam logic [3:0] OP_IDCODE  = 4'b0001;
   localparam logic [3:0] OP_USER    = 4'b0010;
   localparam logic [3:0] OP_BYPASS  = 4'b1111;
   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   typedef enum logic [3:0] {
      TAP_RESET, TAP_IDLE, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
      TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
      TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
   } tap_state_e;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_e;

   // Unknown opcodes fall back to BYPASS so the scan chain stays one bit long.
   function automatic dr_sel_e decode_ir(input logic [3:0] op);
      case (op)
         OP_IDCODE: decode_ir = DR_IDCODE;
         OP_USER:   decode_ir = DR_USER;
         default:   decode_ir = DR_BYPASS;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_shift_reg.sv
`default_nettype none
// ============================================================================
// jtag_shift_reg : capture/shift stage, TDI enters at the MSB, LSB shifts out
// Rev 1.0
// ============================================================================
module jtag_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_capture,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_load,
   input  logic             i_tdi,
   output logic [WIDTH-1:0] o_par,
   output logic             o_ser
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_q <= '0;
      else if (i_capture)
         r_q <= i_load;
      else if (i_shift)
         r_q <= {i_tdi, r_q[WIDTH-1:1]};
   end

   assign o_par = r_q;
   assign o_ser = r_q[0];

endmodule
`default_nettype wire

// File: rtl/jtag_scan_regs.sv
`default_nettype none
// ============================================================================
// jtag_scan_regs : JTAG IR plus BYPASS/IDCODE/USER data registers and TDO mux
// Rev 1.0
// ============================================================================
module jtag_scan_regs
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH     = 4,
   parameter int          USER_WIDTH   = 8,
   parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
   input  logic                  TCK,
   input  logic                  TRST_N,
   input  logic                  TDI,
   input  logic                  tlr,
   input  logic                  capture_ir,
   input  logic                  shift_ir,
   input  logic                  update_ir,
   input  logic                  capture_dr,
   input  logic                  shift_dr,
   input  logic                  update_dr,
   input  logic [USER_WIDTH-1:0] user_in,
   output logic                  TDO,
   output logic                  tdo_en,
   output logic [IR_WIDTH-1:0]   ir_out,
   output logic [USER_WIDTH-1:0] user_out
);

   logic [IR_WIDTH-1:0]   r_ir;
   logic [USER_WIDTH-1:0] r_user_out;
   logic                  r_byp;

   logic w_cap_ir, w_sh_ir, w_upd_ir, w_cap_dr, w_sh_dr, w_upd_dr;
   logic [IR_WIDTH-1:0]   w_ir_par;
   logic [USER_WIDTH-1:0] w_usr_par;
   logic [31:0]           w_id_par;
   logic                  w_ir_ser, w_id_ser, w_usr_ser;
   logic                  w_unused_id;
   dr_sel_e               w_sel;

   // Overlapping strobes resolve in a fixed priority; tlr suppresses all others.
   always_comb begin
      w_cap_ir = 1'b0;
      w_sh_ir  = 1'b0;
      w_upd_ir = 1'b0;
      w_cap_dr = 1'b0;
      w_sh_dr  = 1'b0;
      w_upd_dr = 1'b0;
      if (tlr)             begin end
      else if (capture_ir) w_cap_ir = 1'b1;
      else if (shift_ir)   w_sh_ir  = 1'b1;
      else if (update_ir)  w_upd_ir = 1'b1;
      else if (capture_dr) w_cap_dr = 1'b1;
      else if (shift_dr)   w_sh_dr  = 1'b1;
      else if (update_dr)  w_upd_dr = 1'b1;
   end

   assign w_sel = decode_ir(4'(r_ir));

   jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_sr (
      .clk       (TCK),
      .rst_n     (TRST_N),
      .i_capture (w_cap_ir),
      .i_shift   (w_sh_ir),
      .i_load    (IR_WIDTH'(IR_CAPTURE)),
      .i_tdi     (TDI),
      .o_par     (w_ir_par),
      .o_ser     (w_ir_ser)
   );

   jtag_shift_reg #(.WIDTH(32)) u_id_sr (
      .clk       (TCK),
      .rst_n     (TRST_N),
      .i_capture (w_cap_dr && (w_sel == DR_IDCODE)),
      .i_shift   (w_sh_dr  && (w_sel == DR_IDCODE)),
      .i_load    (IDCODE_VALUE),
      .i_tdi     (TDI),
      .o_par     (w_id_par),
      .o_ser     (w_id_ser)
   );

   jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_usr_sr (
      .clk       (TCK),
      .rst_n     (TRST_N),
      .i_capture (w_cap_dr && (w_sel == DR_USER)),
      .i_shift   (w_sh_dr  && (w_sel == DR_USER)),
      .i_load    (user_in),
      .i_tdi     (TDI),
      .o_par     (w_usr_par),
      .o_ser     (w_usr_ser)
   );

   // IDCODE is read-only, so its parallel image has no consumer.
   assign w_unused_id = ^w_id_par;

   always_ff @(posedge TCK) begin
      if (!TRST_N)
         r_byp <= 1'b0;
      else if (w_cap_dr && (w_sel == DR_BYPASS))
         r_byp <= 1'b0;
      else if (w_sh_dr && (w_sel == DR_BYPASS))
         r_byp <= TDI;
   end

   always_ff @(posedge TCK) begin
      if (!TRST_N)
         r_ir <= IR_WIDTH'(OP_IDCODE);
      else if (tlr)
         r_ir <= IR_WIDTH'(OP_IDCODE);
      else if (w_upd_ir)
         r_ir <= w_ir_par;
   end

   always_ff @(posedge TCK) begin
      if (!TRST_N)
         r_user_out <= '0;
      else if (w_upd_dr && (w_sel == DR_USER))
         r_user_out <= w_usr_par;
   end

   always_comb begin
      TDO = 1'b0;
      if (shift_ir)
         TDO = w_ir_ser;
      else if (shift_dr) begin
         case (w_sel)
            DR_IDCODE: TDO = w_id_ser;
            DR_USER:   TDO = w_usr_ser;
            default:   TDO = r_byp;
         endcase
      end
   end

   assign tdo_en   = shift_ir | shift_dr;
   assign ir_out   = r_ir;
   assign user_out = r_user_out;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_regs.sv
`default_nettype none
// ============================================================================
// tb_jtag_scan_regs : directed scans plus random strobes against a scan model
// Rev 1.0
// ============================================================================
module tb_jtag_scan_regs;

   localparam logic [31:0] IDV = 32'h1234_5001;

   localparam logic [6:0] S_NONE   = 7'b0000000;
   localparam logic [6:0] S_UPD_DR = 7'b0000001;
   localparam logic [6:0] S_SH_DR  = 7'b0000010;
   localparam logic [6:0] S_CAP_DR = 7'b0000100;
   localparam logic [6:0] S_UPD_IR = 7'b0001000;
   localparam logic [6:0] S_SH_IR  = 7'b0010000;
   localparam logic [6:0] S_CAP_IR = 7'b0100000;
   localparam logic [6:0] S_TLR    = 7'b1000000;

   logic       TCK = 1'b0;
   logic       TRST_N, TDI, tlr;
   logic       capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
   logic [7:0] user_in;
   logic       TDO, tdo_en;
   logic [3:0] ir_out;
   logic [7:0] user_out;

   int n_chk  = 0;
   int n_fail = 0;

   // Scan-chain reference state
   logic [3:0]  m_ir, m_irsr;
   logic        m_byp;
   logic [31:0] m_id;
   logic [7:0]  m_usr, m_uo;

   jtag_scan_regs dut (
      .TCK        (TCK),
      .TRST_N     (TRST_N),
      .TDI        (TDI),
      .tlr        (tlr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .user_in    (user_in),
      .TDO        (TDO),
      .tdo_en     (tdo_en),
      .ir_out     (ir_out),
      .user_out   (user_out)
   );

   always #5 TCK = ~TCK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_sel();
      if (m_ir == 4'd1) return 1;
      if (m_ir == 4'd2) return 2;
      return 0;
   endfunction

   function automatic logic m_tdo(input logic [6:0] s);
      if (s[4]) return m_irsr[0];
      if (s[1]) begin
         case (m_sel())
            1:       return m_id[0];
            2:       return m_usr[0];
            default: return m_byp;
         endcase
      end
      return 1'b0;
   endfunction

   task automatic m_reset();
      m_ir = 4'd1; m_irsr = '0; m_byp = 1'b0; m_id = '0; m_usr = '0; m_uo = '0;
   endtask

   task automatic m_step(input logic [6:0] s, input logic tdi, input logic rstn, input logic [7:0] uin);
      if (!rstn) m_reset();
      else if (s[6]) m_ir = 4'd1;
      else if (s[5]) m_irsr = 4'b0101;
      else if (s[4]) m_irsr = (m_irsr >> 1) | (4'(tdi) << 3);
      else if (s[3]) m_ir = m_irsr;
      else if (s[2]) begin
         case (m_sel())
            1:       m_id  = IDV;
            2:       m_usr = uin;
            default: m_byp = 1'b0;
         endcase
      end
      else if (s[1]) begin
         case (m_sel())
            1:       m_id  = (m_id >> 1) | (32'(tdi) << 31);
            2:       m_usr = (m_usr >> 1) | (8'(tdi) << 7);
            default: m_byp = tdi;
         endcase
      end
      else if (s[0]) begin
         if (m_ir == 4'd2) m_uo = m_usr;
      end
   endtask

   // One TCK: drive on the falling edge, check just after, then advance the model.
   task automatic cyc(input logic [6:0] s, input logic tdi, input logic rstn, output logic tdo_o);
      @(negedge TCK);
      {tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = s;
      TDI    = tdi;
      TRST_N = rstn;
      #1;
      check_eq("tdo",      32'(TDO),      32'(m_tdo(s)));
      check_eq("tdo_en",   32'(tdo_en),   32'(s[4] | s[1]));
      check_eq("ir_out",   32'(ir_out),   32'(m_ir));
      check_eq("user_out", 32'(user_out), 32'(m_uo));
      tdo_o = TDO;
      @(posedge TCK);
      m_step(s, tdi, rstn, user_in);
   endtask

   task automatic idle();
      logic t;
      cyc(S_NONE, 1'b0, 1'b1, t);
   endtask

   task automatic load_ir(input logic [3:0] op);
      logic t;
      cyc(S_CAP_IR, 1'b0, 1'b1, t);
      for (int i = 0; i < 4; i++) cyc(S_SH_IR, op[i], 1'b1, t);
      cyc(S_UPD_IR, 1'b0, 1'b1, t);
   endtask

   task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic t;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         cyc(S_SH_DR, din[i], 1'b1, t);
         dout[i] = t;
      end
   endtask

   initial begin
      logic        t;
      logic [31:0] v;
      logic [6:0]  s;
      logic        rn;

      TRST_N = 1'b0; TDI = 1'b0; user_in = 8'h00;
      {tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = S_NONE;
      repeat (2) @(posedge TCK);
      m_reset();

      @(negedge TCK);
      TRST_N = 1'b1;
      #1;
      check_eq("rst_ir_out",   32'(ir_out),   32'h1);
      check_eq("rst_user_out", 32'(user_out), 32'h0);
      check_eq("rst_tdo",      32'(TDO),      32'h0);
      check_eq("rst_tdo_en",   32'(tdo_en),   32'h0);

      // IDCODE readout straight out of reset
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(32, 32'h0, v);
      check_eq("idcode_stream", v, IDV);
      idle();
      check_eq("idcode_ir", 32'(ir_out), 32'h1);

      // IR scan of 1111 reads back the capture pattern
      cyc(S_CAP_IR, 1'b0, 1'b1, t);
      v = '0;
      for (int i = 0; i < 4; i++) begin
         cyc(S_SH_IR, 1'b1, 1'b1, t);
         v[i] = t;
      end
      check_eq("ir_capture_stream", v, 32'b0101);
      cyc(S_UPD_IR, 1'b0, 1'b1, t);
      idle();
      check_eq("ir_bypass", 32'(ir_out), 32'hF);
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(5, 32'b01101, v);
      check_eq("bypass_delay", v, 32'b11010);

      // USER update then capture of a new parallel value
      load_ir(4'b0010);
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(8, 32'hA5, v);
      cyc(S_UPD_DR, 1'b0, 1'b1, t);
      idle();
      check_eq("user_update", 32'(user_out), 32'hA5);
      user_in = 8'h3C;
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(8, 32'h0, v);
      check_eq("user_capture", v, 32'h3C);
      check_eq("user_hold", 32'(user_out), 32'hA5);

      // Undefined opcode behaves as BYPASS
      load_ir(4'b0110);
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(5, 32'b01101, v);
      check_eq("undef_bypass", v, 32'b11010);
      cyc(S_UPD_DR, 1'b0, 1'b1, t);
      idle();
      check_eq("undef_user_out", 32'(user_out), 32'hA5);

      // Reset during the 10th IDCODE shift
      load_ir(4'b0001);
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(9, 32'h0, v);
      cyc(S_SH_DR, 1'b0, 1'b0, t);
      cyc(S_SH_DR, 1'b0, 1'b1, t);
      check_eq("trst_tdo",      32'(t),        32'h0);
      check_eq("trst_ir_out",   32'(ir_out),   32'h1);
      check_eq("trst_user_out", 32'(user_out), 32'h0);
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      scan_dr(32, 32'h0, v);
      check_eq("idcode_after_trst", v, IDV);

      // Test-Logic-Reset forces only the IR
      load_ir(4'b0010);
      user_in = 8'h5A;
      cyc(S_CAP_DR, 1'b0, 1'b1, t);
      cyc(S_UPD_DR, 1'b0, 1'b1, t);
      cyc(S_TLR, 1'b0, 1'b1, t);
      idle();
      check_eq("tlr_ir_out",   32'(ir_out),   32'h1);
      check_eq("tlr_user_out", 32'(user_out), 32'h5A);

      // Random strobes, including overlaps and occasional resets
      for (int n = 0; n < 600; n++) begin
         int r;
         if (n % 50 == 0) begin
            case ($urandom_range(0, 3))
               0:       load_ir(4'b0001);
               1:       load_ir(4'b0010);
               2:       load_ir(4'b1111);
               default: load_ir(4'($urandom));
            endcase
         end
         r  = int'($urandom_range(0, 99));
         rn = (r >= 2);
         if (r < 10)
            s = 7'($urandom);
         else begin
            r = int'($urandom_range(0, 9));
            s = (r >= 7) ? ((r == 9) ? S_SH_DR : S_SH_IR) : 7'(7'b1 << r);
         end
         user_in = 8'($urandom);
         cyc(s, 1'($urandom), rn, t);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtag_scan_regs.md
# jtag_scan_regs

Instruction and data register bank that sits directly downstream of the JTAG TAP controller. Consumes the controller's one-hot state strobes and the serial TDI stream, holds a 4-bit instruction register (IR) and three data registers (BYPASS, IDCODE, USER), and drives TDO. Provides the device-side USER register as a parallel load/capture port for core logic.

## Interface

- IR_WIDTH, 4, instruction register width
- USER_WIDTH, 8, USER data register width
- IDCODE_VALUE, 32'h1234_5001, captured IDCODE; bit 0 must be 1
- TCK  in  1  sole clock; all state updates on rising edge
- TRST_N  in  1  reset, synchronous, active-low
- TDI  in  1  serial data in
- tlr  in  1  TAP in Test-Logic-Reset
- capture_ir / shift_ir / update_ir  in  1 each  TAP IR-path state strobes
- capture_dr / shift_dr / update_dr  in  1 each  TAP DR-path state strobes
- user_in  in  USER_WIDTH  parallel value captured into USER on capture_dr
- TDO  out  1  serial data out
- tdo_en  out  1  high while TDO carries valid shift data
- ir_out  out  IR_WIDTH  current (updated) instruction
- user_out  out  USER_WIDTH  last value updated into USER

## Operation

- Opcodes: IDCODE = 4'b0001, USER = 4'b0010, BYPASS = 4'b1111. Any other opcode selects BYPASS.
- Registers: ir (updated IR), ir_sr (IR shift stage), byp_sr (1 bit), id_sr (32 bits), usr_sr (USER_WIDTH bits), user_out.
- Per rising TCK, first match wins:
  - !TRST_N: ir = IDCODE; ir_sr, byp_sr, id_sr, usr_sr, user_out = 0.
  - tlr: ir = IDCODE; shift stages and user_out hold.
  - capture_ir: ir_sr = 4'b0101.
  - shift_ir: ir_sr = {TDI, ir_sr[IR_WIDTH-1:1]}.
  - update_ir: ir = ir_sr.
  - capture_dr: only the selected DR loads.
    - BYPASS: byp_sr = 0.
    - IDCODE: id_sr = IDCODE_VALUE.
    - USER: usr_sr = user_in.
  - shift_dr: selected DR only; TDI enters at the MSB and the register shifts right. Unselected DRs hold.
  - update_dr: if ir == USER, user_out = usr_sr; otherwise no effect.
- TDO is combinational from registers:
  - shift_ir: TDO = ir_sr[0].
  - shift_dr: TDO = LSB of the selected DR.
  - Otherwise TDO = 0.
- tdo_en = shift_ir | shift_dr.
- ir_out = ir.
- Strobes are mutually exclusive by contract. The priority above is the defined behaviour if they overlap.

## Timing

- Reset values: TDO = 0, tdo_en = 0, ir_out = 4'b0001, user_out = 0.
- Capture-to-TDO latency: the captured LSB appears on TDO in the first shift cycle, with no extra register stage.
- BYPASS: TDI to TDO delay is exactly 1 TCK.
- IDCODE: 32 shift cycles present IDCODE_VALUE LSB first.
- IR scan: the first 4 TDO bits after capture_ir are 1,0,1,0.
- ir_out changes one cycle after the update_ir edge. user_out behaves the same way after update_dr.
- Shifting more bits than the register width is legal. Overflow falls off the LSB.
- TRST_N low mid-shift: takes effect at that edge. The next cycle shows reset values; the partial shift is discarded.
- tlr mid-operation: only ir is forced. A subsequent capture reloads the shift stages normally.

## Structure

- Package jtag_pkg holds:
  - IR opcode localparams (OP_IDCODE, OP_USER, OP_BYPASS)
  - IR capture constant 4'b0101
  - a TAP-state enum shared with the TAP controller
- Sub-module jtag_shift_reg (parameter WIDTH; ports capture, shift, load value, TDI, parallel out, serial out). Instantiated for the IR, IDCODE and USER shift stages. BYPASS is an inline flop.
- The top level contains only selection, the update registers and the TDO mux.

## Test plan

- Reset, then capture_dr followed by 32× shift_dr with TDI = 0 → TDO stream LSB first equals 32'h1234_5001; ir_out = 4'b0001; tdo_en = 1 only during the shifts.
- IR scan shifting in 4'b1111, then update_ir → TDO during the shift is 1,0,1,0; ir_out = 4'b1111. Next, a DR scan with TDI = 1,0,1,1,0 → TDO = 0,1,0,1,1 (1-cycle delay).
- IR = USER; shift in 8'hA5 LSB first, then update_dr → user_out = 8'hA5. Then user_in = 8'h3C, capture_dr and 8 shifts → TDO = 3C LSB first; user_out stays A5 until the next update_dr.
- IR = 4'b0110 (undefined) → DR scan behaves as BYPASS (1-cycle delay, first bit 0); update_dr leaves user_out unchanged.
- TRST_N low during the 10th IDCODE shift → next cycle TDO = 0, ir_out = 4'b0001, user_out = 0. A new capture and shift returns the full IDCODE.
- tlr asserted with IR = USER and user_out = 8'h5A → ir_out = 4'b0001 and user_out stays 8'h5A.
